cpu_if: RTL and testbench

CPU_IF -- requirements
Module: cpu_if

---
 rtl/cpu_if.sv | 174 +++++++++++++++++
 tb/tb_cpu_if.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_if.sv
// cpu_if -- instruction fetch unit.
// Issues one instruction-bus read at a time. It returns each fetched word to
// decode through a registered output stage. A one-entry skid buffer holds a
// word that arrives while decode is stalled. A redirect drops any read that is
// still in flight and restarts fetch at the new address.
module cpu_if #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  // FETCH   : may issue a request.
  // WAIT    : a read is outstanding and its data is wanted.
  // DISCARD : a read is outstanding but a redirect made its data stale.
  // HOLD    : a word is parked in the skid buffer until decode frees up.
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  state_e      state_q,      state_d;
  logic [31:0] fetch_pc_q,   fetch_pc_d;
  logic [31:0] req_pc_q,     req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic [31:0] skid_inst_q,  skid_inst_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] inst_q,       inst_d;
  logic        valid_q,      valid_d;

  // Output-stage load for this cycle. It comes from the bus or the skid buffer.
  logic        load;
  logic [31:0] load_pc;
  logic [31:0] load_inst;

  // Request only from FETCH. A redirect cancels the request combinationally,
  // so the bus never sees an address that is about to be replaced.
  // The request is also held low for the whole reset cycle.
  assign ibus_req_o  = (state_q == ST_FETCH) && !redirect_i && !rst;
  assign ibus_addr_o = fetch_pc_q & WORD_MASK;

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

  // Next-state and datapath decision for the fetch FSM and the output stage.
  always_comb begin
    // NOTE: every variable gets a default before any branch. A path that does
    // not assign a variable would otherwise infer a latch.
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    load         = 1'b0;
    load_pc      = '0;
    load_inst    = '0;

    if (redirect_i) begin
      // A redirect overrides stall. It kills the output and the skid buffer.
      // An outstanding read either completes this cycle (its data is dropped)
      // or is tracked in DISCARD until its data shows up.
      fetch_pc_d   = redirect_pc_i;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      unique case (state_q)
        ST_WAIT, ST_DISCARD: state_d = ibus_rvalid_i ? ST_FETCH : ST_DISCARD;
        default:             state_d = ST_FETCH;
      endcase
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          // The request is always high here, so the grant alone decides.
          // Read data seen in this state has no matching request and is ignored.
          if (ibus_gnt_i) begin
            state_d    = ST_WAIT;
            req_pc_d   = fetch_pc_q & WORD_MASK;
            fetch_pc_d = (fetch_pc_q & WORD_MASK) + 32'd4;
          end
        end
        ST_WAIT: begin
          if (ibus_rvalid_i) begin
            if (stall_i) begin
              skid_valid_d = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_inst_d  = ibus_rdata_i;
              state_d      = ST_HOLD;
            end else begin
              load      = 1'b1;
              load_pc   = req_pc_q;
              load_inst = ibus_rdata_i;
              state_d   = ST_FETCH;
            end
          end
        end
        ST_DISCARD: begin
          if (ibus_rvalid_i) begin
            state_d = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            load         = 1'b1;
            load_pc      = skid_pc_q;
            load_inst    = skid_inst_q;
            skid_valid_d = 1'b0;
            state_d      = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase

      // A stalled decode keeps whatever it is looking at. An unstalled decode
      // consumes the current word, so the output is valid only on a new load.
      if (!stall_i) begin
        valid_d = load;
        if (load) begin
          pc_d   = load_pc;
          inst_d = load_inst;
        end
      end
    end
  end

  // State register for the FSM, the skid buffer and the output stage.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, and it covers the skid data as well. A
    // reset-time snapshot then never shows stale bus data.
    if (rst) begin
      state_q      <= ST_FETCH;
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= '0;
      pc_q         <= '0;
      inst_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from values computed in the same cycle.
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_cpu_if.sv
// tb_cpu_if -- self-checking bench for cpu_if.
// First it runs a table of directed cycles from reset. Then a hand-written
// reset-during-read sequence. Last, a long randomized run checked against a
// transaction-level model: an outstanding-read flag, a stale-read flag, and a
// queue standing in for the skid buffer.
module tb_cpu_if;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  cpu_if dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .valid_o       (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] m_fetch;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_drop;
  logic [63:0] m_skid[$];
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_valid;

  function automatic bit m_req();
    return !rst && !redirect_i && !m_busy && !m_drop && (m_skid.size() == 0);
  endfunction

  // Apply one clock edge to the model, using the inputs currently driven.
  task automatic model_step();
    bit          fetching;
    bit          load;
    logic [31:0] lpc;
    logic [31:0] linst;
    load  = 1'b0;
    lpc   = '0;
    linst = '0;
    if (rst) begin
      m_fetch = RST_PC; m_req_pc = '0; m_busy = 0; m_drop = 0;
      m_skid.delete(); m_pc = '0; m_inst = '0; m_valid = 0;
    end else if (redirect_i) begin
      m_drop  = (m_busy || m_drop) && !ibus_rvalid_i;
      m_busy  = 0;
      m_skid.delete();
      m_fetch = redirect_pc_i;
      m_valid = 0;
    end else begin
      fetching = !m_busy && !m_drop && (m_skid.size() == 0);
      if (fetching) begin
        if (ibus_gnt_i) begin
          m_busy   = 1;
          m_req_pc = m_fetch & 32'hFFFF_FFFC;
          m_fetch  = m_req_pc + 32'd4;
        end
      end else if (m_busy) begin
        if (ibus_rvalid_i) begin
          m_busy = 0;
          if (stall_i) m_skid.push_back({m_req_pc, ibus_rdata_i});
          else begin load = 1'b1; lpc = m_req_pc; linst = ibus_rdata_i; end
        end
      end else if (m_drop) begin
        if (ibus_rvalid_i) m_drop = 0;
      end else if (!stall_i) begin
        {lpc, linst} = m_skid.pop_front();
        load = 1'b1;
      end
      if (!stall_i) begin
        m_valid = load;
        if (load) begin m_pc = lpc; m_inst = linst; end
      end
    end
  endtask

  // Close the previous cycle in the model, then drive the next cycle's inputs
  // at the falling edge. Outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic s, input logic x, input logic [31:0] p,
                       input logic g, input logic v, input logic [31:0] d);
    model_step();
    @(negedge clk);
    rst = r; stall_i = s; redirect_i = x; redirect_pc_i = p;
    ibus_gnt_i = g; ibus_rvalid_i = v; ibus_rdata_i = d;
    #1;
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic valid, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, ".req"},   {31'd0, ibus_req_o}, {31'd0, req});
    check({tag, ".addr"},  ibus_addr_o,          addr);
    check({tag, ".valid"}, {31'd0, valid_o},    {31'd0, valid});
    check({tag, ".pc"},    pc_o,                 pc);
    check({tag, ".inst"},  inst_o,               inst);
  endtask

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        chk;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc, inst;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic x, logic [31:0] p, logic g, logic v,
                              logic [31:0] d, logic c, logic q, logic [31:0] a, logic vo,
                              logic [31:0] pc, logic [31:0] in);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = x; t.rpc = p; t.gnt = g; t.rvalid = v; t.rdata = d;
    t.chk = c; t.req = q; t.addr = a; t.valid = vo; t.pc = pc; t.inst = in;
    return t;
  endfunction

  vec_t vecs[24];

  initial begin
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = '0;
    m_fetch = RST_PC; m_req_pc = '0; m_busy = 0; m_drop = 0;
    m_pc = '0; m_inst = '0; m_valid = 0;

    //              rst s x rpc           g v rdata          chk req addr          v pc            inst
    vecs[0]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,         32'h0);
    vecs[1]  = mk(1, 0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'hBFC0_0000, 0, 32'h0,         32'h0);
    // First fetch: grant, data next cycle, output two cycles after the request.
    vecs[2]  = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'hBFC0_0000, 0, 32'h0,         32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,         0, 1, 32'h3C01_0001,1, 0, 32'hBFC0_0004, 0, 32'h0,         32'h0);
    vecs[4]  = mk(0, 1, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'hBFC0_0004, 1, 32'hBFC0_0000, 32'h3C01_0001);
    // Data arrives under stall: skid buffer, no request, output held.
    vecs[5]  = mk(0, 1, 0, 32'h0,         0, 1, 32'h1111_1111,1, 0, 32'hBFC0_0008, 1, 32'hBFC0_0000, 32'h3C01_0001);
    vecs[6]  = mk(0, 1, 0, 32'h0,         1, 1, 32'hDEAD_BEEF,1, 0, 32'hBFC0_0008, 1, 32'hBFC0_0000, 32'h3C01_0001);
    vecs[7]  = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'hBFC0_0008, 1, 32'hBFC0_0000, 32'h3C01_0001);
    vecs[8]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 0, 32'hBFC0_0008, 1, 32'hBFC0_0000, 32'h3C01_0001);
    vecs[9]  = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'hBFC0_0008, 1, 32'hBFC0_0004, 32'h1111_1111);
    // Redirect while waiting: the late data is dropped.
    vecs[10] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'hBFC0_0008, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[11] = mk(0, 0, 1, 32'h8000_0100, 0, 0, 32'h0,        1, 0, 32'hBFC0_000C, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[12] = mk(0, 0, 0, 32'h0,         0, 1, 32'h2222_2222,1, 0, 32'h8000_0100, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[13] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h8000_0100, 0, 32'hBFC0_0004, 32'h1111_1111);
    // Redirect in the same cycle as data and stall: no skid capture.
    vecs[14] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'h8000_0100, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[15] = mk(0, 1, 1, 32'h8000_0200, 0, 1, 32'h3333_3333,1, 0, 32'h8000_0104, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[16] = mk(0, 1, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h8000_0200, 0, 32'hBFC0_0004, 32'h1111_1111);
    // Unaligned redirect; the grant is ignored while the request is low.
    vecs[17] = mk(0, 0, 1, 32'h8000_0102, 1, 0, 32'h0,        1, 0, 32'h8000_0200, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[18] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h8000_0100, 0, 32'hBFC0_0004, 32'h1111_1111);
    // Address wrap at the top of memory.
    vecs[19] = mk(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 32'h0,        1, 0, 32'h8000_0100, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[20] = mk(0, 0, 0, 32'h0,         1, 0, 32'h0,        1, 1, 32'hFFFF_FFFC, 0, 32'hBFC0_0004, 32'h1111_1111);
    vecs[21] = mk(0, 0, 0, 32'h0,         0, 1, 32'h4444_4444,1, 0, 32'h0000_0000, 0, 32'hBFC0_0004, 32'h1111_1111);
    // Read data seen in FETCH is ignored.
    vecs[22] = mk(0, 0, 0, 32'h0,         0, 1, 32'h5555_5555,1, 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h4444_4444);
    vecs[23] = mk(0, 0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h0000_0000, 0, 32'hFFFF_FFFC, 32'h4444_4444);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
            vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
      if (vecs[i].chk)
        check_all($sformatf("v%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                  vecs[i].pc, vecs[i].inst);
    end

    // Reset while a read is outstanding. The late data must not surface.
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    check_all("rw.req", 1'b1, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 32'h4444_4444);
    drive(1, 1, 1, 32'h1234_5678, 0, 0, 32'h0);
    check({"rw.rstcyc", ".req"}, {31'd0, ibus_req_o}, 32'd0);
    drive(0, 0, 0, 32'h0, 0, 1, 32'h6666_6666);
    check_all("rw.after", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
    check_all("rw.fetch", 1'b1, RST_PC, 1'b0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 1, 32'h7777_7777);
    check_all("rw.wait", 1'b0, RST_PC + 32'd4, 1'b0, 32'h0, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
    check_all("rw.out", 1'b1, RST_PC + 32'd4, 1'b1, RST_PC, 32'h7777_7777);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7) : $urandom;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
            rpc, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
      check_all($sformatf("rnd%0d", n), m_req(), m_fetch & 32'hFFFF_FFFC, m_valid, m_pc, m_inst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
